// File: rtl/axi_word_deserialize_if.sv
// axi_word_deserialize_if: AXI-Stream beat bundle feeding the word deserializer.
// master drives the beat, slave returns tready.
interface axi_word_deserialize_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axi_word_deserialize.sv
// axi_word_deserialize: reassembles BUS_WIDTH beats (LSB slice first) into one DATA_WIDTH word.
// Define AXI_WORD_DESERIALIZE_LAST_CHECK_EN to enable the TLAST framing check.
module axi_word_deserialize #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_word_deserialize_if.slave s,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid_data,
  output logic [15:0]           words_rcvd,
  output logic                  frame_err
);
  localparam int N  = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int SW = N * BUS_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    COLLECT,
    OUT
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]           words_q, words_d;
  logic                  rdy_q, rdy_d;
  logic                  hs;
  logic                  last;

  assign hs       = s.tvalid & s.tready;
  assign last     = (cnt_q == LAST);
  // rdy_q stays low through reset, so tready only depends on hold combinationally
  assign s.tready = rdy_q & ~hold;

  assign data       = data_q;
  assign valid_data = (state_q == OUT);
  assign words_rcvd = words_q;

`ifdef AXI_WORD_DESERIALIZE_LAST_CHECK_EN
  logic fe_q, fe_d;

  always_comb begin
    fe_d = 1'b0;
    if (hs && state_q == COLLECT) begin
      fe_d = last ? ~s.tlast : s.tlast;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fe_q <= 1'b0;
    end else begin
      fe_q <= fe_d;
    end
  end

  assign frame_err = fe_q;
`else
  logic unused_tlast;

  assign unused_tlast = s.tlast;
  assign frame_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    words_d = words_q;
    unique case (state_q)
      COLLECT: begin
        if (hs) begin
          for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) begin
              sr_d[i*BUS_WIDTH +: BUS_WIDTH] = s.tdata;
            end
          end
          if (last) begin
            state_d = OUT;
            cnt_d   = '0;
            data_d  = sr_d[DATA_WIDTH-1:0];
            words_d = words_q + 16'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`ifdef AXI_WORD_DESERIALIZE_LAST_CHECK_EN
          // early TLAST drops the partial word
          if (!last && s.tlast) begin
            cnt_d = '0;
          end
`endif
        end
      end
      OUT: begin
        state_d = COLLECT;
      end
    endcase
    rdy_d = (state_d == COLLECT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      words_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      words_q <= words_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule
